// File: rtl/mul_pkg.sv
// Shared encodings for the sequential radix-4 Booth multiplier:
// controller state and Booth digit, plus the triplet-to-digit decode.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_t;

  // Triplet is {m[2i+1], m[2i], m[2i-1]}.
  function automatic booth_digit_t booth_decode(input logic [2:0] triplet);
    booth_digit_t d;
    case (triplet)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth digit decode and partial-product selection (0, +-M, +-2M),
// sign-extended to K+4 bits so that 2M and its negation both fit.
module booth_r4_enc
  import mul_pkg::*;
#(
  parameter int K = 8
) (
  input  logic [2:0]   triplet,
  input  logic [K+1:0] mcand,
  output logic [K+3:0] pp
);

  logic [K+3:0] m1;
  logic [K+3:0] m2;
  booth_digit_t digit;

  assign m1 = {{2{mcand[K+1]}}, mcand};
  assign m2 = {m1[K+2:0], 1'b0};

  always_comb begin
    digit = booth_decode(triplet);
    pp    = '0;
    case (digit)
      POS1:    pp = m1;
      POS2:    pp = m2;
      NEG1:    pp = -m1;
      NEG2:    pp = -m2;
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/seq_booth_mul.sv
// Sequential radix-4 Booth multiplier: one Booth step per cycle over a
// (K+2)-bit extended multiplier, single shared accumulation adder.
//
// state | meaning
// IDLE  | waiting for start; operands latched on the accepting edge
// CALC  | one Booth step per cycle, N cycles, counted down by cnt
// DONE  | done pulse, result valid; back to IDLE next cycle
module seq_booth_mul
  import mul_pkg::*;
#(
  parameter int K = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           is_signed,
  input  logic [K-1:0]   mul_cand,
  input  logic [K-1:0]   mul_ier,
  output logic           busy,
  output logic           done,
  output logic [2*K-1:0] result
);

  localparam int N  = (K + 3) / 2;
  localparam int W  = K + 2;
  localparam int PW = K + 4;
  localparam int QW = 2 * N;
  localparam int CW = $clog2(N + 1);

  state_t state, state_nxt;

  logic [W-1:0]  mc;
  logic [PW-1:0] p;
  logic [QW-1:0] q;
  logic          qm1;
  logic [CW-1:0] cnt;

  logic          cand_neg;
  logic          ier_neg;
  logic [W-1:0]  mc_ld;
  logic [QW-1:0] q_ld;
  logic [PW-1:0] pp;
  logic [PW-1:0] p_sum;
  logic [PW-1:0] p_new;
  logic [QW-1:0] q_new;

  // Sign bit is only propagated for signed operations; zero-extend otherwise.
  assign cand_neg = is_signed & mul_cand[K-1];
  assign ier_neg  = is_signed & mul_ier[K-1];
  assign mc_ld    = {{2{cand_neg}}, mul_cand};
  assign q_ld     = {{(QW-K){ier_neg}}, mul_ier};

  booth_r4_enc #(.K(K)) u_enc (
    .triplet ({q[1], q[0], qm1}),
    .mcand   (mc),
    .pp      (pp)
  );

  // The only accumulation adder; {p, q} shifts right arithmetically by 2.
  assign p_sum = p + pp;
  assign p_new = {{2{p_sum[PW-1]}}, p_sum[PW-1:2]};
  assign q_new = {p_sum[1:0], q[QW-1:2]};

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mc     <= '0;
      p      <= '0;
      q      <= '0;
      qm1    <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            mc  <= mc_ld;
            p   <= '0;
            q   <= q_ld;
            qm1 <= 1'b0;
            cnt <= CW'(N - 1);
          end
        end
        CALC: begin
          p   <= p_new;
          q   <= q_new;
          qm1 <= q[1];
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // Capture on the final step so result is already valid while done is high.
            result <= {p_new[2*K-QW-1:0], q_new};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_booth_mul.sv
// Directed and swept checks of seq_booth_mul at K=8 and K=5.
module tb_seq_booth_mul;

  localparam int N8 = 5;
  localparam int N5 = 4;

  logic clk = 1'b0;
  logic rst;

  logic        start8, sgn8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;

  logic        start5, sgn5, busy5, done5;
  logic [4:0]  a5, b5;
  logic [9:0]  res5;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int dones8 = 0;

  seq_booth_mul #(.K(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .is_signed(sgn8),
    .mul_cand(a8), .mul_ier(b8), .busy(busy8), .done(done8), .result(res8)
  );

  seq_booth_mul #(.K(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .is_signed(sgn5),
    .mul_cand(a5), .mul_ier(b5), .busy(busy5), .done(done5), .result(res5)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (done8 === 1'b1) dones8++;

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    longint x, y;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    return 16'(x * y);
  endfunction

  function automatic logic [9:0] ref5(input logic [4:0] a, input logic [4:0] b, input logic s);
    longint x, y;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    return 10'(x * y);
  endfunction

  // Called at a negedge with the DUT in IDLE; returns at the negedge where done is seen.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      output int lat, output logic [15:0] r, output int dcyc);
    a8 = a; b8 = b; sgn8 = s; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = ~s;
    lat = -1; r = 16'hxxxx; dcyc = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done8 === 1'b1) begin
        lat = k; r = res8; dcyc = cyc;
        break;
      end
    end
  endtask

  task automatic run5(input logic [4:0] a, input logic [4:0] b, input logic s,
                      output int lat, output logic [9:0] r);
    a5 = a; b5 = b; sgn5 = s; start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    a5 = 5'($urandom); b5 = 5'($urandom); sgn5 = ~s;
    lat = -1; r = 10'hxxx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done5 === 1'b1) begin
        lat = k; r = res5;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    start5 = 1'b0; sgn5 = 1'b0; a5 = '0; b5 = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy8, done8, res8} !== 18'h0) begin
      errors++;
      $display("FAIL reset8 busy/done/result got %b/%b/%h want 0/0/0000", busy8, done8, res8);
    end
    checks++;
    if ({busy5, done5, res5} !== 12'h0) begin
      errors++;
      $display("FAIL reset5 busy/done/result got %b/%b/%h want 0/0/000", busy5, done5, res5);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [7:0]  ta[5] = '{8'd170, 8'd255, 8'd255, 8'hAA, 8'h80};
    logic [7:0]  tb[5] = '{8'd85,  8'd255, 8'd255, 8'h55, 8'h80};
    logic        ts[5] = '{1'b0,   1'b0,   1'b1,   1'b1,  1'b1};
    logic [15:0] te[5] = '{16'h3872, 16'hFE01, 16'h0001, 16'hE372, 16'h4000};
    int lat, dcyc;
    logic [15:0] r;
    for (int i = 0; i < 5; i++) begin
      run8(ta[i], tb[i], ts[i], lat, r, dcyc);
      checks++;
      if (lat != N8) begin
        errors++;
        $display("FAIL directed%0d latency got %0d want %0d", i, lat, N8);
      end
      checks++;
      if (r !== te[i]) begin
        errors++;
        $display("FAIL directed%0d result got %h want %h", i, r, te[i]);
      end
      @(negedge clk);
      checks++;
      if (busy8 !== 1'b0 || res8 !== te[i]) begin
        errors++;
        $display("FAIL directed%0d hold busy/result got %b/%h want 0/%h", i, busy8, res8, te[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int d0, lat;
    d0 = dones8;
    a8 = 8'd170; b8 = 8'd85; sgn8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b1) begin
      errors++;
      $display("FAIL ignore busy_in_calc got %b want 1", busy8);
    end
    a8 = 8'd3; b8 = 8'd3; sgn8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = -1;
    for (int k = 3; k <= 20; k++) begin
      @(negedge clk);
      if (done8 === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != N8 || res8 !== 16'h3872) begin
      errors++;
      $display("FAIL ignore result/latency got %h/%0d want 3872/%0d", res8, lat, N8);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (dones8 - d0 != 1) begin
      errors++;
      $display("FAIL ignore done_count got %0d want 1", dones8 - d0);
    end
  endtask

  task automatic test_reset_mid();
    int d0, lat, dcyc;
    logic [15:0] r;
    a8 = 8'd200; b8 = 8'd77; sgn8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy8 !== 1'b1) begin
      errors++;
      $display("FAIL rstmid busy_before got %b want 1", busy8);
    end
    d0 = dones8;
    rst = 1'b1;
    #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || res8 !== 16'h0) begin
      errors++;
      $display("FAIL rstmid async_clear busy/done/result got %b/%b/%h want 0/0/0000", busy8, done8, res8);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run8(8'd15, 8'd1, 1'b0, lat, r, dcyc);
    checks++;
    if (lat != N8 || r !== 16'd15) begin
      errors++;
      $display("FAIL rstmid next_op result/latency got %0d/%0d want 15/%0d", r, lat, N8);
    end
    @(negedge clk);
    checks++;
    if (dones8 - d0 != 1) begin
      errors++;
      $display("FAIL rstmid done_count got %0d want 1", dones8 - d0);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, c1, c2;
    logic [15:0] r1, r2;
    run8(8'd12, 8'd13, 1'b0, lat1, r1, c1);
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b0) begin
      errors++;
      $display("FAIL b2b idle_gap busy got %b want 0", busy8);
    end
    run8(8'hFE, 8'd100, 1'b1, lat2, r2, c2);
    checks++;
    if (r1 !== 16'd156 || r2 !== 16'hFF38) begin
      errors++;
      $display("FAIL b2b results got %h/%h want 009c/ff38", r1, r2);
    end
    checks++;
    if (lat2 != N8 || c2 - c1 != N8 + 2) begin
      errors++;
      $display("FAIL b2b spacing got %0d want %0d", c2 - c1, N8 + 2);
    end
    @(negedge clk);
  endtask

  task automatic test_sweep();
    int lat, dcyc;
    logic [15:0] r8;
    logic [9:0]  r5;
    logic [7:0]  x8, y8;
    logic [4:0]  x5, y5;
    logic        s;
    for (int i = 0; i < 12; i++) begin
      x8 = 8'($urandom); y8 = 8'($urandom); s = 1'(i % 2);
      run8(x8, y8, s, lat, r8, dcyc);
      checks++;
      if (lat != N8 || r8 !== ref8(x8, y8, s)) begin
        errors++;
        $display("FAIL sweep8 %h*%h s=%b got %h lat %0d want %h lat %0d", x8, y8, s, r8, lat, ref8(x8, y8, s), N8);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 12; i++) begin
      x5 = 5'($urandom); y5 = 5'($urandom); s = 1'(i % 2);
      if (i == 0) begin x5 = 5'h10; y5 = 5'h10; s = 1'b1; end
      if (i == 1) begin x5 = 5'h1F; y5 = 5'h1F; s = 1'b0; end
      run5(x5, y5, s, lat, r5);
      checks++;
      if (lat != N5 || r5 !== ref5(x5, y5, s)) begin
        errors++;
        $display("FAIL sweep5 %h*%h s=%b got %h lat %0d want %h lat %0d", x5, y5, s, r5, lat, ref5(x5, y5, s), N5);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_booth_mul.md
SEQ_BOOTH_MUL -- requirements
Module: seq_booth_mul

Interface
REQ-001 SHALL have parameter K, default 8, meaning operand width in bits (legal K >= 4).
REQ-002 SHALL derive localparam N = (K+3)/2 (integer division), meaning radix-4 iteration count over a (K+2)-bit extended multiplier.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin a multiplication.
REQ-006 SHALL have port is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-007 SHALL have port mul_cand  input  K  multiplicand.
REQ-008 SHALL have port mul_ier  input  K  multiplier.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when result becomes valid.
REQ-011 SHALL have port result  output  2K  product, held until the next accepted start.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 SHALL accept start only in IDLE; the accepting edge latches mul_cand, mul_ier and is_signed, and moves to CALC.
REQ-014 SHALL ignore start in CALC and DONE, with no effect on state or latched operands.
REQ-015 SHALL extend both operands to K+2 bits: sign-extend if latched is_signed=1, zero-extend otherwise.
REQ-016 SHALL in CALC perform one radix-4 Booth step per cycle: digit from triplet {m[2i+1], m[2i], m[2i-1]} with m[-1]=0, select 0/±M/±2M, add to accumulator, arithmetic-shift 2 bits.
REQ-017 SHALL spend exactly N cycles in CALC, counted by an iteration counter, then enter DONE.
REQ-018 SHALL in DONE assert done for exactly one cycle, update result with the low 2K bits of the accumulator, and return to IDLE next cycle.
REQ-019 SHALL give latency: start accepted at edge t gives done=1 during cycle t+N+1; for K=8, done is high 6 cycles after the accepting edge.
REQ-020 SHALL drive busy=1 in CALC and DONE, and 0 in IDLE.
REQ-021 SHALL produce the exact product modulo 2^(2K): unsigned when is_signed=0, two's complement when is_signed=1, including the most-negative operand.
REQ-022 SHALL let start high in the cycle after done (back in IDLE) begin a new operation with no dead cycle beyond DONE.
REQ-023 SHALL be unaffected by input changes on mul_cand, mul_ier and is_signed during CALC.

Reset
REQ-024 SHALL on rst=1 force immediately, regardless of clk: state IDLE, busy 0, done 0, result 0, counter 0, accumulator 0.
REQ-025 SHALL on reset during CALC or DONE abort the operation, produce no done pulse, and leave result at 0.
REQ-026 SHALL honor start on the first rising edge after rst deasserts.

Structure
REQ-027 SHALL place the FSM state encoding and the Booth digit encoding (ZERO, POS1, POS2, NEG1, NEG2) in shared package mul_pkg.
REQ-028 SHALL implement digit decode and partial-product selection in combinational sub-module booth_r4_enc (inputs: triplet, extended multiplicand; output: selected partial product).
REQ-029 SHALL contain exactly one adder for accumulation, i.e. no array of adders.

Verification
REQ-030 Unsigned, K=8: mul_cand=170, mul_ier=85 -> done after 6 cycles, result=14450 (0x3872).
REQ-031 Unsigned boundary: mul_cand=255, mul_ier=255 -> result=0xFE01; signed (is_signed=1), same operands -> result=0x0001.
REQ-032 Signed: mul_cand=0xAA (-86), mul_ier=0x55 (85) -> result=0xE372 (-7310); 0x80 x 0x80 -> 0x4000.
REQ-033 start pulsed again during CALC with different operands -> ignored; first result delivered; exactly one done.
REQ-034 rst asserted mid-CALC -> busy, done and result go 0 asynchronously; no done pulse; the next start (15 x 1) yields 15.
REQ-035 Back-to-back: start in the cycle after done -> second product correct, done spacing N+2 cycles; randomized sweep against a reference model for K=8 and K=5.
